// File: rtl/onehot_decoder.sv
// One-hot to binary index decoder with a one-deep registered valid/ready stage.
// Illegal codes (zero or multiple bits set) are flagged per word and counted, saturating.
module onehot_decoder #(
    parameter int N         = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [N-1:0]          din,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic [$clog2(N)-1:0]  dout,
    output logic                  dout_err,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    input  logic                  clear_err,
    output logic [ERR_CNT_W-1:0]  err_count
);

    localparam int OUT_W = $clog2(N);

    logic [OUT_W-1:0]     dout_q, dout_d;
    logic                 dout_err_q, dout_err_d;
    logic                 dout_valid_q, dout_valid_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

    logic [OUT_W-1:0]     low_idx;
    logic                 illegal;
    logic                 accept;
    logic                 accept_illegal;

    // Lowest set bit wins, so scan from the top and let lower bits overwrite.
    always_comb begin
        low_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (din[i]) begin
                low_idx = OUT_W'(i);
            end
        end
    end

    assign illegal        = (din == '0) || ((din & (din - N'(1))) != '0);
    assign din_ready      = en & (~dout_valid_q | dout_ready);
    assign accept         = din_valid & din_ready;
    assign accept_illegal = accept & illegal;

    always_comb begin
        dout_d       = dout_q;
        dout_err_d   = dout_err_q;
        dout_valid_d = dout_valid_q & ~dout_ready;
        err_count_d  = err_count_q;

        if (accept) begin
            dout_d       = low_idx;
            dout_err_d   = illegal;
            dout_valid_d = 1'b1;
        end

        if (clear_err) begin
            err_count_d = accept_illegal ? ERR_CNT_W'(1) : '0;
        end else if (accept_illegal && (err_count_q != '1)) begin
            err_count_d = err_count_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q       <= '0;
            dout_err_q   <= 1'b0;
            dout_valid_q <= 1'b0;
            err_count_q  <= '0;
        end else begin
            dout_q       <= dout_d;
            dout_err_q   <= dout_err_d;
            dout_valid_q <= dout_valid_d;
            err_count_q  <= err_count_d;
        end
    end

    assign dout       = dout_q;
    assign dout_err   = dout_err_q;
    assign dout_valid = dout_valid_q;
    assign err_count  = err_count_q;

endmodule
